// File: rtl/bcd_sub_if.sv
// Start/busy/done handshake and operand/result bundle
// for the digit-serial BCD subtractor.
`timescale 1ns/1ps
interface bcd_sub_if #(
   parameter int DIGITS = 4
);
   logic                  start;
   logic [4*DIGITS-1:0]   a;
   logic [4*DIGITS-1:0]   b;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   diff;
   logic                  neg;
   logic                  invalid;

   modport master (
      output start, a, b,
      input  busy, done, diff, neg, invalid
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, neg, invalid
   );
endinterface

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial |a - b| in packed BCD, LSD first, via ten's
// complement addition plus a re-complement pass when negative.
`timescale 1ns/1ps
module bcd_subtractor_serial #(
   parameter int DIGITS = 4
) (
   input  logic      clk,
   input  logic      rst,
   bcd_sub_if.slave  io
);
   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    d_q, d_d;
   logic [IW-1:0]   i_q, i_d;
   logic            c_q, c_d;
   logic [W-1:0]    diff_q, diff_d;
   logic            neg_q, neg_d;
   logic            inv_q, inv_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [4:0]      t;
   logic [4:0]      tc;
   logic [3:0]      dig;
   logic            carry;

   function automatic logic has_bad(input logic [W-1:0] x);
      logic bad;
      bad = 1'b0;
      for (int k = 0; k < DIGITS; k++)
         if (x[4*k +: 4] > 4'd9) bad = 1'b1;
      return bad;
   endfunction

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      d_d     = d_q;
      i_d     = i_q;
      c_d     = c_q;
      diff_d  = diff_q;
      neg_d   = neg_q;
      inv_d   = inv_q;
      t       = '0;
      tc      = '0;
      dig     = '0;
      carry   = 1'b0;

      // Both passes share the adder: SUB adds a_i, FIX adds zero.
      if (state_q == SUB)
         t = {1'b0, a_q[{i_q, 2'b00} +: 4]}
           + (5'd9 - {1'b0, b_q[{i_q, 2'b00} +: 4]})
           + {4'b0, c_q};
      else if (state_q == FIX)
         t = (5'd9 - {1'b0, d_q[{i_q, 2'b00} +: 4]})
           + {4'b0, c_q};
      tc = t - 5'd10;
      if (t > 5'd9) begin
         dig   = tc[3:0];
         carry = 1'b1;
      end else begin
         dig   = t[3:0];
      end

      unique case (state_q)
         IDLE: begin
            if (io.start) begin
               a_d = io.a;
               b_d = io.b;
               d_d = '0;
               i_d = '0;
               c_d = 1'b1;
               if (has_bad(io.a) || has_bad(io.b)) begin
                  state_d = DONE;
                  diff_d  = '0;
                  neg_d   = 1'b0;
                  inv_d   = 1'b1;
               end else begin
                  state_d = SUB;
               end
            end
         end
         SUB: begin
            d_d[{i_q, 2'b00} +: 4] = dig;
            i_d = i_q + 1'b1;
            c_d = carry;
            if (i_q == LAST) begin
               if (carry) begin
                  state_d = DONE;
                  diff_d  = d_d;
                  neg_d   = 1'b0;
                  inv_d   = 1'b0;
               end else begin
                  state_d = FIX;
                  i_d     = '0;
                  c_d     = 1'b1;
               end
            end
         end
         FIX: begin
            d_d[{i_q, 2'b00} +: 4] = dig;
            i_d = i_q + 1'b1;
            c_d = carry;
            if (i_q == LAST) begin
               state_d = DONE;
               diff_d  = d_d;
               neg_d   = 1'b1;
               inv_d   = 1'b0;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == SUB) || (state_d == FIX);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         d_q     <= '0;
         i_q     <= '0;
         c_q     <= 1'b0;
         diff_q  <= '0;
         neg_q   <= 1'b0;
         inv_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         d_q     <= d_d;
         i_q     <= i_d;
         c_q     <= c_d;
         diff_q  <= diff_d;
         neg_q   <= neg_d;
         inv_q   <= inv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign io.busy    = busy_q;
   assign io.done    = done_q;
   assign io.diff    = diff_q;
   assign io.neg     = neg_q;
   assign io.invalid = inv_q;
endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Scoreboard bench for bcd_subtractor_serial: integer reference
// model feeds a queue, a negedge monitor checks every done pulse.
`timescale 1ns/1ps
module tb_bcd_subtractor_serial;
   localparam int DIGITS = 4;
   localparam int W = 4 * DIGITS;

   typedef struct {
      logic [W-1:0] diff;
      logic         neg;
      logic         inv;
      int           lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   busy_cnt = 0;
   exp_t sb[$];

   bcd_sub_if #(.DIGITS(DIGITS)) io ();

   bcd_subtractor_serial #(.DIGITS(DIGITS)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int bcd2int(input logic [W-1:0] x);
      int v;
      v = 0;
      for (int k = DIGITS - 1; k >= 0; k--) v = v * 10 + int'(x[4*k +: 4]);
      return v;
   endfunction

   function automatic logic [W-1:0] int2bcd(input int v);
      logic [W-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int k = 0; k < DIGITS; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic is_bad(input logic [W-1:0] x);
      logic bad;
      bad = 1'b0;
      for (int k = 0; k < DIGITS; k++)
         if (x[4*k +: 4] > 4'd9) bad = 1'b1;
      return bad;
   endfunction

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int av, bv;
      if (is_bad(a) || is_bad(b)) begin
         e.diff = '0; e.neg = 1'b0; e.inv = 1'b1; e.lat = 0;
      end else begin
         av = bcd2int(a);
         bv = bcd2int(b);
         e.inv = 1'b0;
         if (av >= bv) begin
            e.diff = int2bcd(av - bv); e.neg = 1'b0; e.lat = DIGITS;
         end else begin
            e.diff = int2bcd(bv - av); e.neg = 1'b1; e.lat = 2 * DIGITS;
         end
      end
      return e;
   endfunction

   function automatic logic [W-1:0] rand_operand();
      logic [W-1:0] r;
      for (int k = 0; k < DIGITS; k++) begin
         if ($urandom_range(0, 15) == 0) r[4*k +: 4] = 4'($urandom);
         else r[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      return r;
   endfunction

   // Monitor: compare each done pulse with the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         busy_cnt = 0;
      end else begin
         if (io.busy) busy_cnt++;
         if (io.done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected none at %0t", $time);
            end else begin
               e = sb.pop_front();
               check("diff", 32'(io.diff), 32'(e.diff));
               check("neg", 32'(io.neg), 32'(e.neg));
               check("invalid", 32'(io.invalid), 32'(e.inv));
               check("busy_cycles", 32'(busy_cnt), 32'(e.lat));
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit spam);
      exp_t e;
      bit seen;
      e = model(a, b);
      @(negedge clk);
      io.start = 1'b1;
      io.a = a;
      io.b = b;
      sb.push_back(e);
      @(negedge clk);
      if (!spam) io.start = 1'b0;
      io.a = rand_operand();
      io.b = rand_operand();
      seen = 1'b0;
      for (int k = 0; k < 3 * DIGITS + 10 && !seen; k++) begin
         if (io.done) seen = 1'b1;
         else begin
            @(negedge clk);
            io.a = rand_operand();
            io.b = rand_operand();
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done expected done for a=%h b=%h", a, b);
         sb.delete();
      end
      @(negedge clk);
      io.start = 1'b0;
      check("diff_held", 32'(io.diff), 32'(e.diff));
   endtask

   initial begin
      io.start = 1'b0;
      io.a = '0;
      io.b = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(io.busy), 32'd0);
      check("rst_done", 32'(io.done), 32'd0);
      check("rst_diff", 32'(io.diff), 32'd0);
      check("rst_neg", 32'(io.neg), 32'd0);
      check("rst_invalid", 32'(io.invalid), 32'd0);
      rst = 1'b0;

      run_op(16'h5432, 16'h1234, 1'b0);
      run_op(16'h1234, 16'h5432, 1'b0);
      run_op(16'h1000, 16'h0001, 1'b0);
      run_op(16'h9999, 16'h9999, 1'b0);
      run_op(16'h0000, 16'h9999, 1'b0);
      run_op(16'h12A4, 16'h0001, 1'b0);
      run_op(16'h0000, 16'h0000, 1'b0);

      for (int n = 0; n < 40; n++) run_op(rand_operand(), rand_operand(), 1'b0);

      // start held high through busy and done must not retrigger
      run_op(16'h1234, 16'h5432, 1'b1);
      repeat (12) @(negedge clk);
      check("no_retrigger_busy", 32'(io.busy), 32'd0);

      run_op(16'h5432, 16'h1234, 1'b0);
      @(negedge clk);
      io.start = 1'b1;
      io.a = 16'h1234;
      io.b = 16'h5432;
      @(negedge clk);
      io.start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", 32'(io.busy), 32'd0);
      check("arst_done", 32'(io.done), 32'd0);
      check("arst_diff", 32'(io.diff), 32'd0);
      check("arst_neg", 32'(io.neg), 32'd0);
      check("arst_invalid", 32'(io.invalid), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("post_rst_idle", 32'(io.busy), 32'd0);

      run_op(16'h1000, 16'h0001, 1'b0);
      run_op(16'h0042, 16'h0050, 1'b0);

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bcd_subtractor_serial.md
Name: bcd_subtractor_serial

Overview:
- Multi-digit, digit-serial BCD subtractor. It is the inverse operation to the team's combinational BCD adder.
- Computes |A − B| in packed BCD plus a sign flag, processing one decimal digit per clock, LSD first.
- Uses ten's-complement addition with decimal correction. A negative result gets a second re-complement pass to produce the magnitude.
- Sits beside the BCD adder in the decimal arithmetic datapath and is controlled by a start/busy/done handshake.

Parameters:
DIGITS, 4, number of BCD digits per operand (≥1); operand width is 4*DIGITS.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only in IDLE
a  input  4*DIGITS  minuend, packed BCD, digit 0 = bits [3:0]
b  input  4*DIGITS  subtrahend, packed BCD
busy  output  1  high while an operation is in progress
done  output  1  one-cycle completion pulse
diff  output  4*DIGITS  |a − b| in packed BCD, held until next completion
neg  output  1  1 when a < b, held with diff
invalid  output  1  1 when any captured digit of a or b > 9, held with diff

Behaviour:
- Reset (async, active-high):
  - State = IDLE.
  - busy = done = neg = invalid = 0; diff = 0.
  - All working registers cleared.
- Reset mid-operation: abort immediately, outputs return to reset values, no done pulse.
- FSM states: IDLE, SUB, FIX, DONE. busy = 1 in SUB and FIX; done = 1 only in DONE. Both are Moore outputs.
- IDLE, start = 1 at edge E0:
  - Capture a and b into working registers.
  - Digit index i = 0, carry c = 1.
  - If any nibble of a or b > 9, go to DONE with result diff = 0, neg = 0, invalid = 1.
  - Otherwise go to SUB.
- start in any state other than IDLE (including the DONE cycle) is ignored. No queuing.
- SUB, one digit per edge:
  - t = a_i + (9 − b_i) + c, computed 5 bits wide.
  - If t > 9: d_i = t − 10, c = 1. Else: d_i = t, c = 0.
  - Store d_i, increment i.
  - After digit DIGITS−1 is processed:
    - c = 1: go to DONE with diff = d, neg = 0, invalid = 0.
    - c = 0: go to FIX with i = 0, c = 1.
- FIX, one digit per edge:
  - t = (9 − d_i) + c, with the same >9 correction.
  - Store r_i.
  - After the last digit, go to DONE with diff = r, neg = 1, invalid = 0. The final carry from FIX is discarded.
- DONE:
  - Lasts exactly one cycle with done = 1, then returns to IDLE.
  - diff, neg and invalid registers load on entry to DONE and hold until the next entry to DONE or reset. They do not change during SUB or FIX.
- Latency, counted from the start-sampling edge E0:
  - done is high during the cycle after edge DIGITS+1 when a ≥ b.
  - done is high during the cycle after edge 2*DIGITS+1 when a < b.
  - done is high during the cycle after edge 1 when the input is invalid.
- Boundaries:
  - a = b gives diff = 0, neg = 0. There is never a "negative zero".
  - Borrow across all digits, e.g. 1000 − 0001, propagates correctly digit-serially.
  - a and b may change freely after E0 without affecting the result.

Test Plan:
- DIGITS = 4, a = 0x5432, b = 0x1234, start pulse:
  - busy high for 4 cycles.
  - Then done pulse with diff = 0x4198, neg = 0, invalid = 0.
- a = 0x1234, b = 0x5432:
  - busy high for 8 cycles (SUB intermediate 0x5802).
  - Then done with diff = 0x4198, neg = 1.
- a = 0x1000, b = 0x0001 gives diff = 0x0999, neg = 0.
- a = 0x9999, b = 0x9999 gives diff = 0x0000, neg = 0.
- a = 0x0000, b = 0x9999 gives diff = 0x9999, neg = 1.
- a = 0x12A4, b = 0x0001: done one cycle after start with invalid = 1, diff = 0, neg = 0.
- Handshake and reset:
  - Re-assert start while busy and during the done cycle: no effect, and the first result is unchanged.
  - Assert rst two cycles into an operation: all outputs go to 0 asynchronously, no done pulse.
  - A fresh start afterwards completes normally.
